// File: rtl/pic_uart_loader.sv
// UART program loader for the PIC core.
// Receives 8N1 bytes and writes 12-bit instruction words into imem.
module pic_uart_loader #(
  parameter int PIC_INSTR_WIDTH        = 12,
  parameter int L2_PIC_INSTR_MEM_DEPTH = 9,
  parameter int CLKS_PER_BIT           = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              uart_rx,
  output logic                              we,
  output logic [L2_PIC_INSTR_MEM_DEPTH-1:0] waddr,
  output logic [PIC_INSTR_WIDTH-1:0]        wdata,
  output logic                              program_mode,
  output logic                              load_err,
  output logic [L2_PIC_INSTR_MEM_DEPTH:0]   word_count
);

  localparam int AW   = L2_PIC_INSTR_MEM_DEPTH;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   WC_MAX  = (AW+1)'(1) << AW;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP,
    R_WAIT
  } rx_st_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_HI,
    P_LO,
    P_WRITE
  } p_st_e;

  rx_st_e        rx_st_q;
  logic          rx_s1_q;
  logic          rx_s2_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [7:0]    rx_byte_q;
  logic          byte_valid_q;
  logic          frame_err_q;

  p_st_e          p_st_q;
  logic [3:0]     hi_q;
  logic [AW-1:0]  addr_q;
  logic           we_q;
  logic [AW-1:0]  waddr_q;
  logic [PIC_INSTR_WIDTH-1:0] wdata_q;
  logic           pm_q;
  logic           err_q;
  logic [AW:0]    wc_q;

  // Bit-timing counter increment.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
  end

  // Synchronise the line and deframe 8N1 bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_st_q      <= R_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_byte_q    <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s1_q      <= uart_rx;
      rx_s2_q      <= rx_s1_q;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (rx_st_q)
        R_IDLE: begin
          if (!rx_s2_q) begin
            cnt_q   <= '0;
            rx_st_q <= R_START;
          end
        end
        R_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (rx_s2_q) begin
              rx_st_q <= R_IDLE;
            end else begin
              bit_q   <= '0;
              rx_st_q <= R_DATA;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        R_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s2_q, shift_q[7:1]};
            if (bit_q == 3'd7) begin
              rx_st_q <= R_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        R_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            rx_st_q <= R_WAIT;
            if (rx_s2_q) begin
              byte_valid_q <= 1'b1;
              rx_byte_q    <= shift_q;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        R_WAIT: begin
          if (rx_s2_q) begin
            rx_st_q <= R_IDLE;
          end
        end
        default: rx_st_q <= R_IDLE;
      endcase
    end
  end

  // Image protocol: sync, hi/lo byte pairs, end marker.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_st_q  <= P_IDLE;
      hi_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      pm_q    <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (frame_err_q) begin
        err_q <= 1'b1;
        if (p_st_q != P_IDLE) begin
          p_st_q <= P_IDLE;
          pm_q   <= 1'b0;
        end
      end else begin
        unique case (p_st_q)
          P_IDLE: begin
            if (byte_valid_q && rx_byte_q == 8'hA5) begin
              p_st_q <= P_HI;
              pm_q   <= 1'b1;
              err_q  <= 1'b0;
              wc_q   <= '0;
              addr_q <= '0;
            end
          end
          P_HI: begin
            if (byte_valid_q) begin
              if (rx_byte_q == 8'hFF) begin
                p_st_q <= P_IDLE;
                pm_q   <= 1'b0;
              end else if (rx_byte_q[7:4] == 4'h0) begin
                hi_q   <= rx_byte_q[3:0];
                p_st_q <= P_LO;
              end else begin
                err_q  <= 1'b1;
                p_st_q <= P_IDLE;
                pm_q   <= 1'b0;
              end
            end
          end
          P_LO: begin
            if (byte_valid_q) begin
              wdata_q <= PIC_INSTR_WIDTH'({hi_q, rx_byte_q});
              waddr_q <= addr_q;
              p_st_q  <= P_WRITE;
            end
          end
          P_WRITE: begin
            we_q   <= 1'b1;
            addr_q <= addr_q + AW'(1);
            if (wc_q != WC_MAX) begin
              wc_q <= wc_q + (AW+1)'(1);
            end
            p_st_q <= P_HI;
          end
          default: p_st_q <= P_IDLE;
        endcase
      end
    end
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign program_mode = pm_q;
  assign load_err     = err_q;
  assign word_count   = wc_q;

endmodule

// File: tb/tb_pic_uart_loader.sv
// Bench for pic_uart_loader: two instances (L2=9 and L2=2)
// share one serial line and are checked against a byte-level model.
module tb_pic_uart_loader;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx  = 1'b1;

  always #5 clk = ~clk;

  logic        we_a, pm_a, le_a;
  logic [8:0]  waddr_a;
  logic [11:0] wdata_a;
  logic [9:0]  wc_a;

  logic        we_b, pm_b, le_b;
  logic [1:0]  waddr_b;
  logic [11:0] wdata_b;
  logic [2:0]  wc_b;

  pic_uart_loader #(
    .PIC_INSTR_WIDTH(12),
    .L2_PIC_INSTR_MEM_DEPTH(9),
    .CLKS_PER_BIT(CPB)
  ) dut_a (
    .clk(clk), .rst(rst), .uart_rx(rx),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
    .program_mode(pm_a), .load_err(le_a),
    .word_count(wc_a)
  );

  pic_uart_loader #(
    .PIC_INSTR_WIDTH(12),
    .L2_PIC_INSTR_MEM_DEPTH(2),
    .CLKS_PER_BIT(CPB)
  ) dut_b (
    .clk(clk), .rst(rst), .uart_rx(rx),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
    .program_mode(pm_b), .load_err(le_b),
    .word_count(wc_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  int depth[2] = '{512, 4};
  bit m_load[2];
  bit m_hi[2];
  bit m_err[2];
  int m_nib[2];
  int m_addr[2];
  int m_wc[2];
  int exp_q[2][$];
  int got_q[2][$];

  logic        pwe[2];
  logic [31:0] pa[2];
  logic [31:0] pd[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_load[d] = 0; m_hi[d] = 0; m_err[d] = 0;
      m_nib[d] = 0; m_addr[d] = 0; m_wc[d] = 0;
      exp_q[d].delete();
      got_q[d].delete();
    end
  endtask

  // Byte-level protocol rules, applied per instance depth.
  task automatic model_byte(int b, bit ok);
    for (int d = 0; d < 2; d++) begin
      if (!ok) begin
        m_err[d] = 1;
        m_load[d] = 0;
        m_hi[d] = 0;
      end else if (!m_load[d]) begin
        if (b == 'hA5) begin
          m_load[d] = 1; m_err[d] = 0; m_hi[d] = 0;
          m_wc[d] = 0; m_addr[d] = 0;
        end
      end else if (!m_hi[d]) begin
        if (b == 'hFF) begin
          m_load[d] = 0;
        end else if (b < 16) begin
          m_nib[d] = b; m_hi[d] = 1;
        end else begin
          m_err[d] = 1; m_load[d] = 0;
        end
      end else begin
        exp_q[d].push_back((m_addr[d] << 16) | (m_nib[d] * 256 + b));
        m_addr[d] = (m_addr[d] + 1) % depth[d];
        if (m_wc[d] < depth[d]) m_wc[d] = m_wc[d] + 1;
        m_hi[d] = 0;
      end
    end
  endtask

  task automatic mon(int d, logic w, logic pm,
                     logic [31:0] a, logic [31:0] dt);
    if (w === 1'b1) begin
      chk($sformatf("we_pm%0d", d), 32'(pm), 1);
      chk($sformatf("we_single%0d", d), 32'(pwe[d]), 0);
      chk($sformatf("addr_setup%0d", d), pa[d], a);
      chk($sformatf("data_setup%0d", d), pd[d], dt);
      got_q[d].push_back(int'((a << 16) | dt));
    end
    pwe[d] = w;
    pa[d]  = a;
    pd[d]  = dt;
  endtask

  initial begin
    pwe = '{1'b0, 1'b0};
    pa  = '{32'd0, 32'd0};
    pd  = '{32'd0, 32'd0};
  end

  always @(negedge clk) begin
    mon(0, we_a, pm_a, 32'(waddr_a), 32'(wdata_a));
    mon(1, we_b, pm_b, 32'(waddr_b), 32'(wdata_b));
  end

  task automatic check_one(int d, string tag, logic pm,
                           logic le, logic [31:0] wc);
    int g, e;
    chk({tag, "_pm"}, 32'(pm), 32'(m_load[d]));
    chk({tag, "_err"}, 32'(le), 32'(m_err[d]));
    chk({tag, "_wc"}, wc, 32'(m_wc[d]));
    while (exp_q[d].size() > 0 && got_q[d].size() > 0) begin
      g = got_q[d].pop_front();
      e = exp_q[d].pop_front();
      chk({tag, "_write"}, g, e);
    end
    chk({tag, "_nwrites"}, got_q[d].size(), exp_q[d].size());
    exp_q[d].delete();
    got_q[d].delete();
  endtask

  task automatic check_all(string tag);
    check_one(0, {tag, "_a"}, pm_a, le_a, 32'(wc_a));
    check_one(1, {tag, "_b"}, pm_b, le_b, 32'(wc_b));
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_we_a"}, 32'(we_a), 0);
    chk({tag, "_waddr_a"}, 32'(waddr_a), 0);
    chk({tag, "_wdata_a"}, 32'(wdata_a), 0);
    chk({tag, "_pm_a"}, 32'(pm_a), 0);
    chk({tag, "_err_a"}, 32'(le_a), 0);
    chk({tag, "_wc_a"}, 32'(wc_a), 0);
    chk({tag, "_we_b"}, 32'(we_b), 0);
    chk({tag, "_waddr_b"}, 32'(waddr_b), 0);
    chk({tag, "_wdata_b"}, 32'(wdata_b), 0);
    chk({tag, "_pm_b"}, 32'(pm_b), 0);
    chk({tag, "_err_b"}, 32'(le_b), 0);
    chk({tag, "_wc_b"}, 32'(wc_b), 0);
  endtask

  // Serialise one frame; rst_at >= 0 pulls reset mid data bit.
  task automatic send(logic [7:0] b, bit ok, int rst_at);
    @(negedge clk) rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == rst_at) begin
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset("midrst");
        model_reset();
        repeat (3) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx = ok;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    model_byte(int'(b), ok);
  endtask

  task automatic sb(logic [7:0] b, string tag);
    send(b, 1'b1, -1);
    check_all(tag);
  endtask

  initial begin
    int n;
    logic [7:0] hb, lb;
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    sb(8'hA5, "t1_sync");
    sb(8'h0C, "t1_h0");
    sb(8'h25, "t1_l0");
    sb(8'h0A, "t1_h1");
    sb(8'h00, "t1_l1");
    sb(8'hFF, "t1_end");

    sb(8'h12, "t2_junk0");
    sb(8'h34, "t2_junk1");
    sb(8'hA5, "t2_sync");
    sb(8'hFF, "t2_end");

    sb(8'hA5, "t3_sync");
    sb(8'h31, "t3_bad");
    sb(8'hA5, "t3_resync");
    sb(8'hA5, "t3_a5_in_hi");
    sb(8'hA5, "t3_sync2");
    sb(8'hFF, "t3_end");

    sb(8'hA5, "t4_sync");
    sb(8'h01, "t4_h0");
    sb(8'h23, "t4_l0");
    sb(8'h04, "t4_h1");
    send(8'h56, 1'b0, -1);
    check_all("t4_frame");
    sb(8'hA5, "t4_sync2");
    sb(8'hFF, "t4_end");

    sb(8'hA5, "t5_sync");
    for (int i = 1; i <= 5; i++) begin
      sb(8'h00, "t5_hi");
      sb(8'(i), "t5_lo");
    end
    sb(8'hFF, "t5_end");

    @(negedge clk) rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_all("glitch");

    sb(8'hA5, "t6_sync");
    sb(8'h01, "t6_h0");
    send(8'hC3, 1'b1, 3);
    check_all("t6_after_rst");
    sb(8'hA5, "t6_sync2");
    sb(8'h0B, "t6_h");
    sb(8'hCD, "t6_l");
    sb(8'hFF, "t6_end");

    for (int img = 0; img < 5; img++) begin
      sb(8'hA5, "rnd_sync");
      n = $urandom_range(1, 6);
      for (int w = 0; w < n; w++) begin
        if ($urandom_range(0, 9) == 0)
          hb = 8'($urandom_range(16, 254));
        else
          hb = 8'($urandom_range(0, 15));
        lb = 8'($urandom);
        sb(hb, "rnd_hi");
        if ($urandom_range(0, 11) == 0) begin
          send(lb, 1'b0, -1);
          check_all("rnd_frame");
        end else begin
          sb(lb, "rnd_lo");
        end
      end
      sb(8'hFF, "rnd_end");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pic_uart_loader.md
Name: pic_uart_loader

Overview:
- UART program loader directly upstream of the cpu's program interface; drives cpu.we/waddr/wdata/program_mode.
- Receives an instruction image over a single 8N1 serial line and writes it into instruction memory word by word.
- Holds the cpu in program mode while loading and releases it on an end marker.
- Replaces the bench write task for image loading in system-level tests.

Parameters:
PIC_INSTR_WIDTH, 12, instruction word width (fixed 12 for this protocol)
L2_PIC_INSTR_MEM_DEPTH, 9, instruction address width
CLKS_PER_BIT, 16, clk cycles per UART bit (min 4)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-low
uart_rx  input  1  serial data in, idle high, 8N1, LSB first; asynchronous to clk
we  output  1  instruction memory write strobe to cpu
waddr  output  L2_PIC_INSTR_MEM_DEPTH  write address to cpu
wdata  output  PIC_INSTR_WIDTH  write data to cpu
program_mode  output  1  high while an image load is in progress
load_err  output  1  sticky error flag, cleared on next sync byte or reset
word_count  output  L2_PIC_INSTR_MEM_DEPTH+1  words written since last sync byte

Behaviour:
- Reset (rst low, async): we=0, waddr=0, wdata=0, program_mode=0, load_err=0, word_count=0, FSM=IDLE, receiver idle. Reset mid-frame or mid-load abandons everything; no partial write.
- RX synchronisation: uart_rx passes through a 2-flop synchroniser before use.
- Start-bit detection: falling edge starts a count; the line is resampled at CLKS_PER_BIT/2.
  - If high at that sample, it is a glitch: return to idle, no error.
- Data bits: sampled every CLKS_PER_BIT thereafter at bit centre, 8 bits LSB first.
- Stop bit: sampled at its centre.
  - Stop=1: one-cycle internal byte_valid with the byte.
  - Stop=0: framing error; byte discarded, load_err=1. If in a load, abort to IDLE and drop program_mode.
  - Receiver waits for line high before hunting the next start bit.
- Protocol FSM states: IDLE, HI, LO, WRITE.
  - IDLE: byte 0xA5 -> HI; program_mode=1, load_err=0, word_count=0, address counter=0. Other bytes are ignored.
  - HI: byte 0xFF -> IDLE, program_mode=0 (end of image). Byte with [7:4]==0 -> store [3:0] as wdata[11:8], go to LO. Any other value -> load_err=1, IDLE, program_mode=0.
  - LO: any byte -> wdata[7:0]; waddr=address counter; go to WRITE.
  - WRITE: we=1 for exactly one cycle; address counter+1, word_count+1; go to HI.
- Write timing:
  - we rises on the clk edge after byte_valid of the LO byte.
  - waddr/wdata are valid the cycle before and during we, and are held until the next write.
- Address wrap: the counter is L2_PIC_INSTR_MEM_DEPTH bits and wraps 2^L2-1 -> 0 without error. word_count saturates at 2^L2.
- A second 0xA5 received in HI state is treated as a data/error byte per HI rules (not a resync).
- program_mode stays high from the 0xA5 byte_valid cycle+1 until the cycle after the 0xFF byte_valid or an abort. we never asserts while program_mode is low.

Test Plan:
1. Send 0xA5, 0x0C,0x25, 0x0A,0x00, 0xFF -> two single-cycle we pulses: (waddr 0, wdata 0xC25), (waddr 1, wdata 0xA00). word_count=2; program_mode falls after 0xFF; load_err=0.
2. In IDLE send 0x12, 0x34 -> no we, program_mode stays 0. Then 0xA5 -> program_mode=1.
3. After 0xA5 send HI byte 0x31 -> load_err=1, program_mode=0, no we. Next 0xA5 clears load_err.
4. Frame with stop bit 0 during LO byte -> load_err=1, program_mode=0, no write for that word. Earlier words remain written.
5. L2=2: send 0xA5 then 5 words (0x001..0x005) -> writes to addresses 0,1,2,3,0; word_count saturates at 4.
6. Assert rst low midway through LO byte -> all outputs return to reset values immediately. After release, a full image loads normally from address 0.
